// File: rtl/requant_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : requant_stage
// Brief    : 4-stage multi-channel requantiser (acc -> saturated activation)
// Revision : 1.0 - initial release
// ============================================================================
module requant_stage #(
    parameter int                    PRECISION              = 8,
    parameter int                    ACC_WIDTH              = 32,
    parameter int                    Z_WEIGHTS              = 5,
    parameter int                    M_WIDTH                = 32,
    parameter int                    SHIFT                  = 32,
    parameter int                    OUTPUT_STAGE_PRECISION = 64,
    parameter int                    CHANNELS               = 16,
    parameter logic [M_WIDTH-1:0]    DEFAULT_M              = M_WIDTH'(2094967296)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         relu_en,
    input  logic                         cfg_we,
    input  logic [$clog2(CHANNELS)-1:0]  cfg_addr,
    input  logic [M_WIDTH-1:0]           cfg_m,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_last,
    input  logic [ACC_WIDTH-1:0]         acc,
    input  logic [ACC_WIDTH-1:0]         ai,
    input  logic [ACC_WIDTH-1:0]         bias,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PRECISION-1:0]         out,
    output logic                         out_last,
    output logic [$clog2(CHANNELS)-1:0]  out_ch
);

    localparam int OW = OUTPUT_STAGE_PRECISION;
    localparam int AW = $clog2(CHANNELS);

    localparam logic signed [OW-1:0] c_zw      = OW'(Z_WEIGHTS);
    localparam logic signed [OW-1:0] c_round   = OW'(1) << (SHIFT - 1);
    localparam logic signed [OW-1:0] c_relu_hi = (OW'(1) << PRECISION) - OW'(1);
    localparam logic signed [OW-1:0] c_sat_hi  = (OW'(1) << (PRECISION - 1)) - OW'(1);
    localparam logic signed [OW-1:0] c_sat_lo  = -(OW'(1) << (PRECISION - 1));
    localparam logic [AW-1:0]        c_ch_max  = AW'(CHANNELS - 1);

    logic [M_WIDTH-1:0]          m_tab_q [CHANNELS];
    logic [AW-1:0]               ch_q, ch_d;
    logic                        w_advance, w_accept, w_cfg_hit;
    logic signed [OW-1:0]        w_acc_x, w_ai_x, w_c, w_p, w_r, w_bias_x;

    logic                        s1_valid_q, s2_valid_q, s3_valid_q;
    logic signed [OW-1:0]        s1_c_q, s2_p_q, s3_r_q;
    logic [M_WIDTH-1:0]          s1_m_q;
    logic [ACC_WIDTH-1:0]        s1_bias_q, s2_bias_q;
    logic [AW-1:0]               s1_ch_q, s2_ch_q, s3_ch_q;
    logic                        s1_last_q, s2_last_q, s3_last_q;

    logic                        out_valid_q, out_last_q;
    logic [PRECISION-1:0]        out_q, out_d;
    logic [AW-1:0]               out_ch_q;

    assign w_advance = !out_valid_q || out_ready;
    assign w_accept  = in_valid && w_advance;
    assign in_ready  = w_advance;
    assign w_cfg_hit = cfg_we && ({1'b0, cfg_addr} < (AW + 1)'(CHANNELS));

    assign w_acc_x  = {{(OW - ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
    assign w_ai_x   = {{(OW - ACC_WIDTH){ai[ACC_WIDTH-1]}}, ai};
    assign w_bias_x = {{(OW - ACC_WIDTH){s2_bias_q[ACC_WIDTH-1]}}, s2_bias_q};
    assign w_c      = w_acc_x - c_zw * w_ai_x;
    // Multipliers are positive magnitudes; zero-extension lets 2^31 be used at M_WIDTH=32.
    assign w_p      = s1_c_q * $signed({{(OW - M_WIDTH){1'b0}}, s1_m_q});
    assign w_r      = ((s2_p_q + c_round) >>> SHIFT) + w_bias_x;

    always_comb begin
        ch_d = ch_q;
        if (w_accept) begin
            ch_d = (in_last || ch_q == c_ch_max) ? '0 : ch_q + AW'(1);
        end
    end

    always_comb begin
        out_d = s3_r_q[PRECISION-1:0];
        if (relu_en) begin
            if (s3_r_q[OW-1])              out_d = '0;
            else if (s3_r_q > c_relu_hi)   out_d = '1;
        end else begin
            if (s3_r_q < c_sat_lo)         out_d = {1'b1, {(PRECISION - 1){1'b0}}};
            else if (s3_r_q > c_sat_hi)    out_d = {1'b0, {(PRECISION - 1){1'b1}}};
        end
    end

    // Table read for S1 happens at the same edge as any write, so a colliding beat sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                m_tab_q[i] <= DEFAULT_M;
            end
        end else if (w_cfg_hit) begin
            m_tab_q[cfg_addr] <= cfg_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q        <= '0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            ch_q <= ch_d;
            if (w_advance) begin
                s1_valid_q  <= in_valid;
                s2_valid_q  <= s1_valid_q;
                s3_valid_q  <= s2_valid_q;
                out_valid_q <= s3_valid_q;
                out_q       <= out_d;
                out_last_q  <= s3_last_q;
                out_ch_q    <= s3_ch_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_advance) begin
            s1_c_q    <= w_c;
            s1_m_q    <= m_tab_q[ch_q];
            s1_bias_q <= bias;
            s1_ch_q   <= ch_q;
            s1_last_q <= in_last;
            s2_p_q    <= w_p;
            s2_bias_q <= s1_bias_q;
            s2_ch_q   <= s1_ch_q;
            s2_last_q <= s1_last_q;
            s3_r_q    <= w_r;
            s3_ch_q   <= s2_ch_q;
            s3_last_q <= s2_last_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_requant_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_requant_stage
// Brief    : scoreboard bench for requant_stage (4-channel instance)
// Revision : 1.0 - initial release
// ============================================================================
module tb_requant_stage;

    localparam int          CH    = 4;
    localparam logic [31:0] DEF_M = 32'd2094967296;
    localparam logic [31:0] M31   = 32'h8000_0000;
    localparam logic [31:0] M30   = 32'h4000_0000;

    logic        clk, rst, relu_en, cfg_we, in_valid, in_ready, in_last;
    logic        out_valid, out_ready, out_last;
    logic [1:0]  cfg_addr, out_ch;
    logic [31:0] cfg_m, acc, ai, bias;
    logic [7:0]  out;

    requant_stage #(.CHANNELS(CH)) dut (
        .clk(clk), .rst(rst), .relu_en(relu_en), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_m(cfg_m), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .acc(acc), .ai(ai),
        .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_last(out_last), .out_ch(out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] o;
        logic [1:0] ch;
        logic       last;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_pop;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_out = 0;
    int          stall_cycles = 0;
    logic        stalled = 1'b0;
    logic [7:0]  prev_out;
    logic [1:0]  prev_ch;
    logic        prev_last;
    logic [1:0]  tb_ch;
    logic [31:0] mshadow [CH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input int a, input int aiv, input int b,
                                         input logic [31:0] m, input logic relu);
        longint c, p, r;
        c = longint'(a) - 64'sd5 * longint'(aiv);
        p = c * longint'({32'b0, m});
        r = ((p + 64'sd2147483648) >>> 32) + longint'(b);
        if (relu) begin
            if (r < 0)   r = 0;
            if (r > 255) r = 255;
        end else begin
            if (r < -128) r = -128;
            if (r > 127)  r = 127;
        end
        return r[7:0];
    endfunction

    task automatic send(input int a, input int aiv, input int b, input logic l, input logic [7:0] e);
        int w;
        acc = a; ai = aiv; bias = b; in_last = l; in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w == 50) check_eq("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        sb.push_back('{o: e, ch: tb_ch, last: l});
        tb_ch = (l || tb_ch == 2'(CH - 1)) ? 2'd0 : tb_ch + 2'd1;
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_m(input int a, input int aiv, input int b, input logic l);
        send(a, aiv, b, l, model(a, aiv, b, mshadow[tb_ch], relu_en));
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] m);
        cfg_we = 1'b1; cfg_addr = addr; cfg_m = m;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        mshadow[addr] = m;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        check_eq("drain_left", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !out_ready) begin
                check_eq("stall_in_ready", {31'b0, in_ready}, 32'd0);
                if (stalled) begin
                    check_eq("stall_out", {24'b0, out}, {24'b0, prev_out});
                    check_eq("stall_ch", {30'b0, out_ch}, {30'b0, prev_ch});
                    check_eq("stall_last", {31'b0, out_last}, {31'b0, prev_last});
                end
                prev_out = out; prev_ch = out_ch; prev_last = out_last;
                stalled = 1'b1;
                stall_cycles++;
            end else begin
                stalled = 1'b0;
            end
            if (out_valid) n_out++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    e_pop = sb.pop_front();
                    check_eq("out", {24'b0, out}, {24'b0, e_pop.o});
                    check_eq("out_ch", {30'b0, out_ch}, {30'b0, e_pop.ch});
                    check_eq("out_last", {31'b0, out_last}, {31'b0, e_pop.last});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n0;
        rst = 1'b1; relu_en = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_m = '0;
        in_valid = 1'b0; in_last = 1'b0; acc = '0; ai = '0; bias = '0; out_ready = 1'b1;
        tb_ch = '0;
        for (int i = 0; i < CH; i++) mshadow[i] = DEF_M;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_out", {24'b0, out}, 32'd0);
        check_eq("rst_out_ch", {30'b0, out_ch}, 32'd0);
        check_eq("rst_out_last", {31'b0, out_last}, 32'd0);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Rounding, bias and saturation on channel 0
        cfg_write(2'd0, M31);
        send(100, 0, 10, 1'b1, 8'd60);
        send(101, 0, 10, 1'b1, 8'd61);
        send(200, 20, 0, 1'b1, 8'd50);
        send(1000, 0, 10, 1'b1, 8'd255);
        send(-100, 0, 10, 1'b1, 8'd0);
        drain();
        relu_en = 1'b0;
        send(-100, 0, 10, 1'b1, 8'hD8);
        send(1000, 0, 0, 1'b1, 8'd127);
        drain();
        relu_en = 1'b1;

        // Per-channel multipliers and channel wrap
        cfg_write(2'd1, M30);
        cfg_write(2'd2, M31);
        cfg_write(2'd3, M31);
        send(400, 0, 0, 1'b0, 8'd200);
        send(400, 0, 0, 1'b0, 8'd100);
        send(400, 0, 0, 1'b0, 8'd200);
        send(400, 0, 0, 1'b0, 8'd200);
        send(400, 0, 0, 1'b0, 8'd200);
        send(400, 0, 0, 1'b1, 8'd100);
        // in_last returns the counter to 0
        send(400, 0, 0, 1'b0, 8'd200);
        send(400, 0, 0, 1'b0, 8'd100);
        send(400, 0, 0, 1'b1, 8'd200);
        send(400, 0, 0, 1'b0, 8'd200);
        send(400, 0, 0, 1'b1, 8'd100);
        drain();

        // Unstalled latency
        send(100, 0, 10, 1'b1, 8'd60);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
        end
        check_eq("latency", 32'(n + 1), 32'd4);
        drain();

        // Backpressure: 3-cycle hold at the first output
        stall_cycles = 0;
        fork
            begin
                int w;
                w = 0;
                while (!out_valid && w < 40) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                if (w == 40) check_eq("stall_wait_timeout", {31'b0, out_valid}, 32'd1);
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 8; i++) send_m(37 * i - 90, i, i - 4, 1'b0);
            end
        join
        drain();
        check_eq("stall_cycles", 32'(stall_cycles), 32'd3);

        // Write collides with a ch-0 acceptance: that beat sees the old multiplier
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_m = M30;
        send(400, 0, 0, 1'b1, 8'd200);
        cfg_we = 1'b0;
        mshadow[0] = M30;
        send(400, 0, 0, 1'b1, 8'd100);
        drain();

        // Reset with beats in flight
        send_m(300, 0, 0, 1'b0);
        send_m(300, 0, 0, 1'b0);
        send_m(300, 0, 0, 1'b0);
        rst = 1'b1;
        sb.delete();
        tb_ch = '0;
        for (int i = 0; i < CH; i++) mshadow[i] = DEF_M;
        n0 = n_out;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_eq("no_out_after_rst", 32'(n_out), 32'(n0));
        check_eq("in_ready_after_rst", {31'b0, in_ready}, 32'd1);
        send(200, 0, 0, 1'b1, 8'd98);
        send(1000, 0, 0, 1'b1, 8'd255);
        drain();
        check_eq("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
